// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset-domain sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_LOCK_SETTLE = 3'd1,
        ST_RELEASE     = 3'd2,
        ST_RUN         = 3'd3,
        ST_SOFT_ASSERT = 3'd4,
        ST_SOFT_DONE   = 3'd5
    } rst_seq_state_e;

    localparam logic [7:0] LOCK_LOST_MAX = 8'd255;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by an async active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_domain_sequencer.sv
// Sequences per-domain resets after PLL lock, with soft-reset handshake and lock-loss recovery.
//
// state          | meaning
// WAIT_LOCK      | all domains in reset, waiting for synchronized lock
// LOCK_SETTLE    | lock seen, letting it settle for LOCK_DELAY cycles
// RELEASE        | releasing domains one per STAGE_DELAY cycles, index 0 first
// RUN            | all domains out of reset, all_ready high
// SOFT_ASSERT    | soft reset: all domains held for SOFT_HOLD cycles
// SOFT_DONE      | ack high, waiting for the requester to drop its request
module rst_domain_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int LOCK_DELAY  = 100,
    parameter int STAGE_DELAY = 16,
    parameter int SOFT_HOLD   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    output logic                   soft_rst_ack,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   all_ready,
    output logic [2:0]             state_dbg,
    output logic [7:0]             lock_lost_cnt
);

    localparam int MAX_DELAY = max3(LOCK_DELAY, STAGE_DELAY, SOFT_HOLD);
    localparam int CNT_W     = $clog2(MAX_DELAY + 1);
    localparam int IDX_W     = $clog2(NUM_DOMAINS + 1);

    rst_seq_state_e         state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [NUM_DOMAINS-1:0] dom_nxt;
    logic                   ready_nxt, ack_nxt;
    logic [7:0]             lost_nxt;
    logic                   lock_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .clr (reset),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        dom_nxt   = domain_rst_n;
        ready_nxt = all_ready;
        ack_nxt   = soft_rst_ack;
        lost_nxt  = lock_lost_cnt;

        // Lock loss outranks every other event in every active state.
        if (state != ST_WAIT_LOCK && !lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            dom_nxt   = '0;
            ready_nxt = 1'b0;
            ack_nxt   = 1'b0;
            if (lock_lost_cnt != LOCK_LOST_MAX)
                lost_nxt = lock_lost_cnt + 8'd1;
        end else begin
            unique case (state)
                ST_WAIT_LOCK: begin
                    dom_nxt   = '0;
                    ready_nxt = 1'b0;
                    ack_nxt   = 1'b0;
                    if (lock_s) begin
                        state_nxt = ST_LOCK_SETTLE;
                        cnt_nxt   = '0;
                    end
                end
                ST_LOCK_SETTLE: begin
                    if (cnt == CNT_W'(LOCK_DELAY - 1)) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == CNT_W'(STAGE_DELAY - 1)) begin
                        for (int i = 0; i < NUM_DOMAINS; i++)
                            if (idx == IDX_W'(i)) dom_nxt[i] = 1'b1;
                        idx_nxt = idx + 1'b1;
                        cnt_nxt = '0;
                        if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
                            state_nxt = ST_RUN;
                            ready_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (soft_rst_req) begin
                        state_nxt = ST_SOFT_ASSERT;
                        dom_nxt   = '0;
                        ready_nxt = 1'b0;
                        cnt_nxt   = '0;
                    end
                end
                ST_SOFT_ASSERT: begin
                    if (cnt == CNT_W'(SOFT_HOLD - 1)) begin
                        state_nxt = ST_SOFT_DONE;
                        ack_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_SOFT_DONE: begin
                    if (!soft_rst_req) begin
                        state_nxt = ST_RELEASE;
                        ack_nxt   = 1'b0;
                        idx_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = ST_WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_WAIT_LOCK;
            cnt           <= '0;
            idx           <= '0;
            domain_rst_n  <= '0;
            all_ready     <= 1'b0;
            soft_rst_ack  <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            domain_rst_n  <= dom_nxt;
            all_ready     <= ready_nxt;
            soft_rst_ack  <= ack_nxt;
            lock_lost_cnt <= lost_nxt;
        end
    end

    assign state_dbg = state;

endmodule
